sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  - Single-clock FIFO buffer between a write producer and a read consumer.
//  - Sits behind the fifo_intf interface bundle (clk_i, rst_i, data, enables, flags).
//  - Stores up to DEPTH words and provides a registered read data output.
//  - Reports full and empty status, and flags illegal accesses (overflow/underflow) on error_o.
// PARAMETERS
//  WIDTH  8   data word width in bits
//  DEPTH  16  number of storage entries; must be a power of 2 and >= 2
//  PTR_W  $clog2(DEPTH)  derived localparam; address width
// PORTS
//  clk_i    in   1      single clock; all logic updates on rising edge
//  rst_i    in   1      reset, synchronous, active-high
//  wdata_i  in   WIDTH  write data, sampled on the edge where wr_en_i=1
//  wr_en_i  in   1      write request
//  rd_en_i  in   1      read request
//  rdata_o  out  WIDTH  read data, registered
//  empty_o  out  1      FIFO holds 0 entries
//  full_o   out  1      FIFO holds DEPTH entries
//  error_o  out  1      registered 1-cycle flag for an illegal access
// BEHAVIOUR
//  - Reset (rst_i=1 at a rising edge): wr_ptr=rd_ptr=0, rdata_o=0, empty_o=1, full_o=0, error_o=0.
//    Storage contents are don't-care. Reset mid-operation discards all stored data at that edge.
//  - Pointers are PTR_W+1 bits; the MSB is the wrap toggle.
//    empty = (wr_ptr==rd_ptr).
//    full = (addr bits equal) && (MSBs differ).
//    Pointers wrap naturally from DEPTH-1 to 0.
//  - empty_o and full_o are combinational from the pointers; they are valid the cycle after the pointer update.
//  - Write: wr_en_i=1 and not full -> mem[wr_ptr]<=wdata_i, wr_ptr++.
//  - Read: rd_en_i=1 and not empty -> rdata_o<=mem[rd_ptr], rd_ptr++.
//    Latency: data appears on rdata_o after the same edge, so it is usable in the following cycle.
//  - No read: rdata_o holds its last value.
//  - Write while full: write is dropped, pointers are unchanged, error_o<=1 on that edge.
//  - Read while empty: read is dropped, rdata_o is unchanged, error_o<=1 on that edge.
//  - Simultaneous wr_en_i and rd_en_i:
//    - Not empty and not full: both proceed; occupancy is unchanged.
//    - Full: both proceed (the read frees a slot in the same edge); no error; full_o stays 1.
//    - Empty: the write proceeds; the read is an underflow (error_o<=1); rdata_o is unchanged.
//      No write-through bypass.
//  - error_o: any other cycle -> 0. It is not sticky.
//  - Ordering: strict first-in first-out; no data reordering or duplication.
// STRUCTURE
//  - Package fifo_pkg: WIDTH/DEPTH default constants; no typedefs beyond a word_t = logic[WIDTH-1:0].
//  - One natural sub-module: fifo_mem, a DEPTH x WIDTH register array.
//    - Synchronous write port; async read address.
//    - sync_fifo registers the read output.
//  - Pointer/flag logic stays in sync_fifo.
// TESTING
//  - Reset: hold rst_i=1 for 2 cycles -> empty_o=1, full_o=0, error_o=0, rdata_o=0.
//  - Fill then drain:
//    - Write 16 words 0x01..0x10 -> full_o=1 after the 16th write.
//    - Then 16 reads -> rdata_o=0x01..0x10 in order, empty_o=1 after the last read, error_o never set.
//  - Overflow: with the FIFO full, write 0xAA -> error_o=1 for exactly one cycle.
//    A drain still returns 0x01..0x10 with no 0xAA.
//  - Underflow: when empty, assert rd_en_i -> error_o=1 for one cycle; rdata_o keeps its previous value.
//  - Simultaneous access:
//    - With 3 entries, assert wr+rd for 5 cycles -> occupancy stays 3, output order preserved, no error.
//    - With the FIFO full, assert wr+rd -> full_o stays 1, no error.
//  - Wrap and reset:
//    - Write/read 40 random words in interleaved bursts -> all compared in order (pointers wrap twice).
//    - Then assert rst_i with 5 entries held -> empty_o=1 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and word type for the single-clock FIFO.
package fifo_pkg;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 16;

    typedef logic [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
interface fifo_intf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] wdata_i;
    logic             wr_en_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] rdata_o;
    logic             empty_o;
    logic             full_o;
    logic             error_o;

    modport master (
        output wdata_i, wr_en_i, rd_en_i,
        input  rdata_o, empty_o, full_o, error_o
    );

    modport slave (
        input  wdata_i, wr_en_i, rd_en_i,
        output rdata_o, empty_o, full_o, error_o
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and overflow/underflow error flag.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic    clk_i,
    input  logic    rst_i,
    fifo_intf.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] mem_rdata;
    logic             error_q;
    logic             empty;
    logic             full;
    logic             do_wr;
    logic             do_rd;
    logic             illegal;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                   (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    // A read on a full FIFO frees the slot the write lands in on the same edge.
    assign do_rd   = bus.rd_en_i && !empty;
    assign do_wr   = bus.wr_en_i && (!full || do_rd);
    assign illegal = (bus.wr_en_i && !do_wr) || (bus.rd_en_i && !do_rd);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk    (clk_i),
        .wr_en  (do_wr),
        .wr_addr(wr_ptr[PTR_W-1:0]),
        .wr_data(bus.wdata_i),
        .rd_addr(rd_ptr[PTR_W-1:0]),
        .rd_data(mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= illegal;
            if (do_wr) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
                rdata_q <= mem_rdata;
            end
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.empty_o = empty;
    assign bus.full_o  = full;
    assign bus.error_o = error_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomized bench for sync_fifo against a queue reference model.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int unsigned DEPTH = DEPTH_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_intf #(.WIDTH(WIDTH_DEF)) ifc ();

    sync_fifo #(
        .WIDTH(WIDTH_DEF),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (ifc.slave)
    );

    word_t q[$];
    word_t exp_rdata;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic exp_err);
        check({tag, "_rdata"}, 32'(ifc.rdata_o), 32'(exp_rdata));
        check({tag, "_empty"}, 32'(ifc.empty_o), 32'(q.size() == 0));
        check({tag, "_full"},  32'(ifc.full_o),  32'(q.size() == DEPTH));
        check({tag, "_error"}, 32'(ifc.error_o), 32'(exp_err));
    endtask

    // One clock of traffic; the model applies the FIFO rules to a queue.
    task automatic step(input string tag, input logic wr, input logic rd, input word_t d);
        int unsigned occ;
        logic        rd_ok;
        logic        wr_ok;
        occ = q.size();
        ifc.wr_en_i = wr;
        ifc.rd_en_i = rd;
        ifc.wdata_i = d;
        @(posedge clk);
        #1;
        ifc.wr_en_i = 1'b0;
        ifc.rd_en_i = 1'b0;
        rd_ok = rd && (occ > 0);
        wr_ok = wr && ((occ < DEPTH) || rd_ok);
        if (rd_ok) exp_rdata = q.pop_front();
        if (wr_ok) q.push_back(d);
        check_flags(tag, (rd && !rd_ok) || (wr && !wr_ok));
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_rdata = '0;
        check_flags("reset", 1'b0);
    endtask

    initial begin
        word_t prev;
        int unsigned written;
        int unsigned burst;
        ifc.wdata_i = '0;
        ifc.wr_en_i = 1'b0;
        ifc.rd_en_i = 1'b0;
        exp_rdata   = '0;

        do_reset(2);

        // Fill then drain
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, word_t'(i + 1));
        check("full_after_fill", 32'(ifc.full_o), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step("drain", 1'b0, 1'b1, '0);
            check("drain_order", 32'(ifc.rdata_o), 32'(i + 1));
        end
        check("empty_after_drain", 32'(ifc.empty_o), 32'd1);

        // Overflow
        for (int i = 0; i < 16; i++) step("fill2", 1'b1, 1'b0, word_t'(i + 1));
        step("overflow", 1'b1, 1'b0, 8'hAA);
        step("overflow_clear", 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            step("drain2", 1'b0, 1'b1, '0);
            check("drain2_order", 32'(ifc.rdata_o), 32'(i + 1));
        end

        // Underflow keeps the previous read data
        prev = ifc.rdata_o;
        step("underflow", 1'b0, 1'b1, '0);
        check("underflow_hold", 32'(ifc.rdata_o), 32'(prev));
        step("underflow_clear", 1'b0, 1'b0, '0);

        // Simultaneous on empty: write proceeds, read underflows
        step("sim_empty", 1'b1, 1'b1, 8'h5C);
        step("sim_empty_rd", 1'b0, 1'b1, '0);

        // Simultaneous with 3 entries
        for (int i = 0; i < 3; i++) step("pre3", 1'b1, 1'b0, word_t'(8'h30 + i));
        for (int i = 0; i < 5; i++) step("sim3", 1'b1, 1'b1, word_t'(8'h40 + i));
        check("sim3_occupancy", 32'(q.size()), 32'd3);
        for (int i = 0; i < 3; i++) step("sim3_drain", 1'b0, 1'b1, '0);
        check("sim3_last", 32'(ifc.rdata_o), 32'h44);

        // Simultaneous while full
        for (int i = 0; i < 16; i++) step("fill3", 1'b1, 1'b0, word_t'($urandom));
        step("sim_full", 1'b1, 1'b1, 8'h77);
        check("sim_full_flag", 32'(ifc.full_o), 32'd1);
        for (int i = 0; i < 16; i++) step("drain3", 1'b0, 1'b1, '0);
        check("sim_full_tail", 32'(ifc.rdata_o), 32'h77);

        // Interleaved random bursts, 40 words, pointers wrap
        written = 0;
        while (written < 40) begin
            burst = $urandom_range(1, 7);
            for (int i = 0; i < int'(burst) && written < 40; i++) begin
                step("wrap_wr", 1'b1, 1'b0, word_t'($urandom));
                written++;
            end
            burst = $urandom_range(1, 7);
            for (int i = 0; i < int'(burst); i++) step("wrap_rd", 1'b0, 1'b1, '0);
        end
        while (q.size() > 0) step("wrap_flush", 1'b0, 1'b1, '0);

        // Fully random traffic
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom), 1'($urandom), word_t'($urandom));

        // Reset with 5 entries held
        while (q.size() > 0) step("pre_rst_flush", 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, word_t'($urandom));
        do_reset(1);
        check("rst_empty", 32'(ifc.empty_o), 32'd1);
        step("post_rst_rd", 1'b0, 1'b1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
